// File: rtl/note_player_pkg.sv
// Shared constants, tuning table and state encoding for the note playback stage.
package note_player_pkg;

  localparam int unsigned NUM_STRINGS = 6;
  localparam int unsigned NUM_FRETS   = 5;
  localparam int unsigned HP_W        = 19;
  localparam int unsigned ADDR_W      = 6;
  localparam int unsigned WORD_W      = 32;

  // Half-period in 50 MHz cycles; rows E2 A2 D3 G3 B3 E4, columns fret 0..4.
  localparam logic [HP_W-1:0] HALF_PERIOD [NUM_STRINGS][NUM_FRETS] = '{
    '{19'd303360, 19'd286329, 19'd270274, 19'd255105, 19'd240787},
    '{19'd227273, 19'd214517, 19'd202477, 19'd191113, 19'd180387},
    '{19'd170262, 19'd160706, 19'd151686, 19'd143173, 19'd135137},
    '{19'd127553, 19'd120394, 19'd113636, 19'd107258, 19'd101238},
    '{19'd101238, 19'd95556,  19'd90193,  19'd85131,  19'd80353},
    '{19'd75843,  19'd71587,  19'd67568,  19'd63776,  19'd60197}
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY,
    S_DONE
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s == S_FETCH) || (s == S_WAIT) || (s == S_PLAY);
  endfunction

endpackage

// File: rtl/note_player_tone_voice.sv
// Square-wave tone generator for one string: phase flips every half_period cycles.
module tone_voice
  import note_player_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        restart,
  input  logic        enable,
  input  logic [18:0] half_period,
  output logic        phase
);

  logic [HP_W-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;

  // Reload with half_period-1 so each phase level lasts exactly half_period cycles.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (enable) begin
      if (cnt_q == '0) begin
        cnt_d   = half_period - HP_W'(1);
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q - HP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/note_player.sv
// Steps through recorded note words on tempo beats and streams the six-voice mix to the codec.
module note_player
  import note_player_pkg::*;
#(
  parameter int unsigned RAM_LATENCY = 2,
  parameter logic [31:0] AMP         = 32'h0100_0000,
  parameter bit          LOOP        = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        stop,
  input  logic        beat,
  input  logic [5:0]  last_addr,
  input  logic [31:0] ram_q,
  input  logic        audio_ready,
  output logic [5:0]  ram_address,
  output logic [31:0] audio_out,
  output logic        audio_write,
  output logic        playing,
  output logic [31:0] note
);

  localparam int unsigned WAIT_W = 4;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [WORD_W-1:0]   note_q, note_d;
  logic [WORD_W-1:0]   audio_out_q, audio_out_d;
  logic                audio_write_q, audio_write_d;
  logic                playing_q, playing_d;

  logic                   voice_restart;
  logic                   src_active;
  logic [NUM_STRINGS-1:0] voice_on;
  logic [NUM_STRINGS-1:0] voice_phase;
  logic [HP_W-1:0]        voice_hp [NUM_STRINGS];
  logic [WORD_W-1:0]      mix_c;

  // Sequencer: stop beats start beats beat; beats outside S_PLAY are dropped.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wait_d        = wait_q;
    note_d        = note_q;
    voice_restart = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
      note_d  = '0;
    end else if (start) begin
      state_d = S_FETCH;
      addr_d  = '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          wait_d  = WAIT_W'(RAM_LATENCY);
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (wait_q <= WAIT_W'(1)) begin
            wait_d        = '0;
            note_d        = ram_q;
            voice_restart = 1'b1;
            state_d       = S_PLAY;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
        S_PLAY: begin
          if (beat) begin
            if (addr_q == last_addr) begin
              if (LOOP) begin
                addr_d  = '0;
                state_d = S_FETCH;
              end else begin
                note_d  = '0;
                state_d = S_DONE;
              end
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_FETCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Highest set fret wins for each string.
  always_comb begin
    for (int s = 0; s < NUM_STRINGS; s++) begin
      voice_on[s] = 1'b0;
      voice_hp[s] = '0;
      for (int f = 0; f < NUM_FRETS; f++) begin
        if (note_q[NUM_STRINGS*f + s]) begin
          voice_on[s] = 1'b1;
          voice_hp[s] = HALF_PERIOD[s][f];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_STRINGS; g++) begin : g_voice
    tone_voice u_voice (
      .clk        (clk),
      .resetn     (resetn),
      .restart    (voice_restart),
      .enable     (voice_on[g]),
      .half_period(voice_hp[g]),
      .phase      (voice_phase[g])
    );
  end

  always_comb begin
    mix_c = '0;
    for (int s = 0; s < NUM_STRINGS; s++) begin
      if (voice_on[s]) begin
        mix_c = mix_c + (voice_phase[s] ? AMP : (32'd0 - AMP));
      end
    end
  end

  // Codec push: one-cycle strobe, never back to back, silent outside playback.
  always_comb begin
    playing_d     = is_busy(state_d);
    src_active    = (state_q == S_PLAY) ||
                    (((state_q == S_FETCH) || (state_q == S_WAIT)) && (note_q != '0));
    audio_out_d   = audio_out_q;
    audio_write_d = 1'b0;
    if (playing_d && src_active) begin
      if (audio_ready && !audio_write_q) begin
        audio_out_d   = mix_c;
        audio_write_d = 1'b1;
      end
    end else begin
      audio_out_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wait_q        <= '0;
      note_q        <= '0;
      audio_out_q   <= '0;
      audio_write_q <= 1'b0;
      playing_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wait_q        <= wait_d;
      note_q        <= note_d;
      audio_out_q   <= audio_out_d;
      audio_write_q <= audio_write_d;
      playing_q     <= playing_d;
    end
  end

  assign ram_address = addr_q;
  assign audio_out   = audio_out_q;
  assign audio_write = audio_write_q;
  assign playing     = playing_q;
  assign note        = note_q;

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player: one stopping instance and one looping instance share stimulus.
module tb_note_player;
  import note_player_pkg::*;

  localparam logic [31:0] AMP  = 32'h0100_0000;
  localparam logic [31:0] NAMP = 32'hFF00_0000;

  logic        clk = 1'b0;
  logic        resetn, start, stop, beat, audio_ready;
  logic [5:0]  last_addr, loop_last;
  logic [31:0] ram_q, loop_ram_q;
  logic [5:0]  ram_address, loop_ram_address;
  logic [31:0] audio_out, loop_audio_out, note, loop_note;
  logic        audio_write, loop_audio_write, playing, loop_playing;

  logic [31:0] mem [64];
  logic [5:0]  addr_r, loop_addr_r;

  int checks   = 0;
  int failures = 0;
  int consec   = 0;
  logic prev_w  = 1'b0;
  logic prev_lw = 1'b0;

  always #5 clk = ~clk;

  note_player #(.RAM_LATENCY(2), .AMP(AMP), .LOOP(1'b0)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .beat(beat),
    .last_addr(last_addr), .ram_q(ram_q), .audio_ready(audio_ready),
    .ram_address(ram_address), .audio_out(audio_out), .audio_write(audio_write),
    .playing(playing), .note(note)
  );

  note_player #(.RAM_LATENCY(2), .AMP(AMP), .LOOP(1'b1)) u_loop (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .beat(beat),
    .last_addr(loop_last), .ram_q(loop_ram_q), .audio_ready(audio_ready),
    .ram_address(loop_ram_address), .audio_out(loop_audio_out), .audio_write(loop_audio_write),
    .playing(loop_playing), .note(loop_note)
  );

  // Two-cycle RAM: registered address, registered data.
  always @(posedge clk) begin
    addr_r      <= ram_address;
    ram_q       <= mem[addr_r];
    loop_addr_r <= loop_ram_address;
    loop_ram_q  <= mem[loop_addr_r];
  end

  always @(negedge clk) begin
    if (audio_write && prev_w) consec++;
    if (loop_audio_write && prev_lw) consec++;
    prev_w  = audio_write;
    prev_lw = loop_audio_write;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  task automatic restart_play();
    stop = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
  endtask

  task automatic next_sample(input string tag, input logic [31:0] exp);
    bit seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      tick();
      seen = audio_write;
    end
    if (seen) check(tag, audio_out, exp);
    else check({tag, "_timeout"}, 32'(audio_write), 32'd1);
  endtask

  initial begin
    int n;
    bit found;
    int writes;
    start = 1'b0; stop = 1'b0; beat = 1'b0; audio_ready = 1'b1;
    last_addr = 6'd2; loop_last = 6'd1; resetn = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 32'h0000_0001;
    repeat (3) tick();
    check("rst_addr", 32'(ram_address), 32'd0);
    check("rst_out", audio_out, 32'd0);
    check("rst_write", 32'(audio_write), 32'd0);
    check("rst_playing", 32'(playing), 32'd0);
    check("rst_note", note, 32'd0);

    resetn = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("e2_note", note, 32'h1);
    check("e2_playing", 32'(playing), 32'd1);
    check("e2_hp", 32'(dut.voice_hp[0]), 32'd303360);
    next_sample("e2_pos", AMP);
    next_sample("e2_neg", NAMP);

    mem[0] = 32'h0000_0041;
    restart_play();
    check("fret_prio_note", note, 32'h41);
    check("fret_prio_hp", 32'(dut.voice_hp[0]), 32'd286329);
    next_sample("f2_pos", AMP);
    next_sample("f2_neg", NAMP);

    mem[0] = 32'h0000_0003;
    restart_play();
    check("two_str_note", note, 32'h3);
    next_sample("two_str_pos", 32'h0200_0000);
    next_sample("two_str_neg", 32'hFE00_0000);

    // String 5 fret 4 (half-period 60197): low stretch seen as hp-1 cycles between strobes.
    mem[0] = 32'h2000_0000;
    restart_play();
    next_sample("e4f4_pos", AMP);
    next_sample("e4f4_neg", NAMP);
    n = 0; found = 1'b0;
    while (!found && n < 70000) begin
      tick();
      n++;
      if (audio_write && audio_out == AMP) found = 1'b1;
    end
    check("e4f4_low_cycles", 32'(n), 32'd60196);

    mem[0] = 32'h1; mem[1] = 32'h2; mem[2] = 32'h4;
    restart_play();
    check("seq_a0", 32'(ram_address), 32'd0);
    check("loop_a0", 32'(loop_ram_address), 32'd0);
    pulse_beat();
    check("seq_a1", 32'(ram_address), 32'd1);
    check("loop_a1", 32'(loop_ram_address), 32'd1);
    repeat (4) tick();
    check("seq_note1", note, 32'h2);
    pulse_beat();
    check("seq_a2", 32'(ram_address), 32'd2);
    check("loop_wrap0", 32'(loop_ram_address), 32'd0);
    repeat (4) tick();
    pulse_beat();
    check("done_playing", 32'(playing), 32'd0);
    check("done_note", note, 32'd0);
    check("loop_a1_again", 32'(loop_ram_address), 32'd1);
    check("loop_playing", 32'(loop_playing), 32'd1);
    writes = 0;
    repeat (10) begin
      tick();
      if (audio_write) writes++;
    end
    check("done_no_write", 32'(writes), 32'd0);
    check("done_out", audio_out, 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_restart_addr", 32'(ram_address), 32'd0);
    check("done_restart_playing", 32'(playing), 32'd1);
    pulse_beat();
    check("beat_in_fetch", 32'(ram_address), 32'd0);
    repeat (3) tick();
    check("beat_in_fetch_note", note, 32'h1);
    check("beat_in_fetch_hold", 32'(ram_address), 32'd0);

    pulse_beat();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_wait", 32'(ram_address), 32'd0);
    repeat (3) tick();
    check("start_in_wait_note", note, 32'h1);

    pulse_beat();
    repeat (4) tick();
    stop = 1'b1; beat = 1'b1;
    tick();
    stop = 1'b0; beat = 1'b0;
    check("stop_beat_addr", 32'(ram_address), 32'd0);
    check("stop_beat_playing", 32'(playing), 32'd0);
    check("stop_beat_note", note, 32'd0);
    check("stop_beat_out", audio_out, 32'd0);
    check("loop_stop_out", loop_audio_out, 32'd0);
    check("loop_stop_note", loop_note, 32'd0);

    mem[0] = 32'h3;
    restart_play();
    next_sample("pre_reset_pos", 32'h0200_0000);
    resetn = 1'b0;
    tick();
    check("midrst_addr", 32'(ram_address), 32'd0);
    check("midrst_out", audio_out, 32'd0);
    check("midrst_write", 32'(audio_write), 32'd0);
    check("midrst_playing", 32'(playing), 32'd0);
    check("midrst_note", note, 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'(S_IDLE));
    resetn = 1'b1;
    writes = 0;
    repeat (10) begin
      tick();
      if (audio_write) writes++;
    end
    check("post_rst_no_write", 32'(writes), 32'd0);

    check("no_back_to_back", 32'(consec), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
